// File: rtl/oled_frame_scheduler.sv
// oled_frame_scheduler
//   Shares the 96x64 OLED pixel stream between three pixel sources
//   (0 = splash, 1 = text scroller, 2 = status overlay). Ownership is
//   re-arbitrated only at frame boundaries. The policy is round-robin with a
//   per-owner frame quota. The owner's RGB565 pixel is muxed onto the display
//   driver input, with a transparent colour key replaced by the background.
//
// Ports
//   clk          OLED clock, single domain
//   reset        asynchronous, active-low
//   frame_begin  one-cycle frame-start strobe from the display driver
//   req[2:0]     level requests, bit n = source n
//   src_pixels   source n pixel on [16n+15:16n]
//   bg_color     colour used when idle or when the owner pixel is transparent
//   grant[2:0]   one-hot owner, 000 when idle
//   frame_tick   one-cycle pulse the cycle after each frame_begin
//   scroll_step  one-cycle pulse every SCROLL_DIV frames, coincident with frame_tick
//   hold_count   frames held by the current owner, saturating at 255
//   pixel_data   registered pixel to the display driver
module oled_frame_scheduler #(
    parameter int          MAX_FRAMES  = 16,
    parameter int          SCROLL_DIV  = 4,
    parameter logic [15:0] TRANSPARENT = 16'hF81F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_begin,
    input  logic [2:0]  req,
    input  logic [47:0] src_pixels,
    input  logic [15:0] bg_color,
    output logic [2:0]  grant,
    output logic        frame_tick,
    output logic        scroll_step,
    output logic [7:0]  hold_count,
    output logic [15:0] pixel_data
);

    typedef enum logic {IDLE, OWNED} state_t;

    localparam logic [7:0] QUOTA_LAST = 8'(MAX_FRAMES - 1);
    localparam logic [7:0] DIV_LAST   = 8'(SCROLL_DIV - 1);

    state_t      state;
    logic [1:0]  cur;        // index of the current owner (valid in OWNED)
    logic [1:0]  last;       // round-robin pointer: most recent owner
    logic [7:0]  frame_cnt;

    logic [2:0]  others;
    logic        keep;
    logic        found;
    logic [1:0]  pick;
    logic [1:0]  idx;
    logic [15:0] owner_pix;

    // Index (base + k) mod 3 for the round-robin scan.
    function automatic logic [1:0] rr_index(input logic [1:0] base, input int k);
        int s;
        s = int'(base) + k;
        return 2'(s % 3);
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] i);
        logic [2:0] v;
        v = 3'b000;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Arbitration decision, consumed only when frame_begin is high.
    always_comb begin
        others = req & ~grant;
        keep   = (state == OWNED) && req[cur] &&
                 ((hold_count < QUOTA_LAST) || (others == 3'b000));
        found  = 1'b0;
        pick   = last;
        idx    = 2'd0;
        for (int k = 1; k <= 3; k++) begin
            idx = rr_index(last, k);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        case (cur)
            2'd0:    owner_pix = src_pixels[15:0];
            2'd1:    owner_pix = src_pixels[31:16];
            default: owner_pix = src_pixels[47:32];
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cur         <= 2'd0;
            last        <= 2'd2;
            grant       <= 3'b000;
            hold_count  <= 8'd0;
            frame_cnt   <= 8'd0;
            frame_tick  <= 1'b0;
            scroll_step <= 1'b0;
            pixel_data  <= 16'h0000;
        end else begin
            frame_tick  <= frame_begin;
            scroll_step <= frame_begin && (frame_cnt == DIV_LAST);

            if (frame_begin) begin
                frame_cnt <= (frame_cnt == DIV_LAST) ? 8'd0 : frame_cnt + 8'd1;

                if (keep) begin
                    hold_count <= sat_inc(hold_count);
                end else if (found) begin
                    state      <= OWNED;
                    cur        <= pick;
                    last       <= pick;
                    grant      <= onehot(pick);
                    hold_count <= 8'd0;
                end else begin
                    // Nobody requesting: release, keep the round-robin pointer.
                    state      <= IDLE;
                    grant      <= 3'b000;
                    hold_count <= 8'd0;
                end
            end

            // Output pixel stage: follows the registered grant by one cycle.
            if ((state == IDLE) || (owner_pix == TRANSPARENT))
                pixel_data <= bg_color;
            else
                pixel_data <= owner_pix;
        end
    end

endmodule

// File: tb/tb_oled_frame_scheduler.sv
// Scoreboard bench for oled_frame_scheduler (MAX_FRAMES=2, SCROLL_DIV=4).
// Each frame pulse pushes the expected {grant, hold_count, scroll_step};
// a monitor pops and compares whenever the DUT raises frame_tick.
module tb_oled_frame_scheduler;

    logic        clk;
    logic        reset;
    logic        frame_begin;
    logic [2:0]  req;
    logic [47:0] src_pixels;
    logic [15:0] bg_color;
    logic [2:0]  grant;
    logic        frame_tick;
    logic        scroll_step;
    logic [7:0]  hold_count;
    logic [15:0] pixel_data;

    typedef struct packed {
        logic [2:0] g;
        logic [7:0] h;
        logic       s;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   frame_no = 0;   // frames since last reset release

    oled_frame_scheduler #(
        .MAX_FRAMES (2),
        .SCROLL_DIV (4),
        .TRANSPARENT(16'hF81F)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_begin(frame_begin),
        .req        (req),
        .src_pixels (src_pixels),
        .bg_color   (bg_color),
        .grant      (grant),
        .frame_tick (frame_tick),
        .scroll_step(scroll_step),
        .hold_count (hold_count),
        .pixel_data (pixel_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, elapsed=%0t limit=200000", $time);
        $fatal(1, "watchdog");
    end

    // Monitor: one scoreboard entry per frame_tick cycle.
    always @(negedge clk) begin
        exp_t e;
        if (reset && frame_tick) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL frame_tick unexpected: got grant=%b hold=%0d scroll=%b, required no tick",
                         grant, hold_count, scroll_step);
            end else begin
                e = exp_q.pop_front();
                if (grant !== e.g || hold_count !== e.h || scroll_step !== e.s)
                    $display("FAIL frame_result: got grant=%b hold=%0d scroll=%b, required grant=%b hold=%0d scroll=%b",
                             grant, hold_count, scroll_step, e.g, e.h, e.s);
                else
                    n_pass++;
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req_v);
        n_checks++;
        if (act !== req_v)
            $display("FAIL %s: got %h, required %h", name, act, req_v);
        else
            n_pass++;
    endtask

    task automatic push_frame(input logic [2:0] g, input logic [7:0] h);
        exp_t e;
        frame_no++;
        e.g = g;
        e.h = h;
        e.s = (frame_no % 4 == 0);
        exp_q.push_back(e);
    endtask

    // Single frame_begin pulse; returns 1 ns after edge T+1.
    task automatic frame(input logic [2:0] g, input logic [7:0] h);
        push_frame(g, h);
        @(posedge clk); #1 frame_begin = 1'b1;
        @(posedge clk); #1 frame_begin = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        frame_no = 0;
    endtask

    initial begin
        reset       = 1'b0;
        frame_begin = 1'b0;
        req         = 3'b000;
        src_pixels  = 48'h0;
        bg_color    = 16'h001F;

        // Reset and idle; frame_begin during reset must be ignored.
        repeat (2) @(posedge clk);
        #1 frame_begin = 1'b1;
        tick();
        check("rst_grant", 16'(grant), 16'h0);
        check("rst_pixel", pixel_data, 16'h0000);
        check("rst_hold", 16'(hold_count), 16'h0);
        check("rst_tick", 16'(frame_tick), 16'h0);
        check("rst_scroll", 16'(scroll_step), 16'h0);
        reset = 1'b1;
        frame_begin = 1'b0;
        tick();
        check("idle_pixel_bg", pixel_data, 16'h001F);
        check("idle_no_tick", 16'(frame_tick), 16'h0);
        frame(3'b000, 8'd0);                       // frame 1
        check("idle_grant", 16'(grant), 16'h0);

        // Single requester: grant at T+1, pixel at T+2, hold counts up.
        req = 3'b010;
        src_pixels[31:16] = 16'hFD20;
        frame(3'b010, 8'd0);                       // frame 2
        check("single_pixel_t1", pixel_data, 16'h001F);
        tick();
        check("single_pixel_t2", pixel_data, 16'hFD20);
        frame(3'b010, 8'd1);                       // frame 3
        frame(3'b010, 8'd2);                       // frame 4 (scroll)

        // Quota rotation from a fresh reset, MAX_FRAMES=2.
        do_reset();
        check("rst2_pixel_bg", pixel_data, 16'h0000);
        src_pixels[15:0] = 16'h0AA0;
        req = 3'b011;
        frame(3'b001, 8'd0);
        frame(3'b001, 8'd1);
        frame(3'b010, 8'd0);
        frame(3'b010, 8'd1);                       // frame 4 (scroll)
        frame(3'b001, 8'd0);
        frame(3'b001, 8'd1);                       // frame 6
        tick();
        check("rot_owner0_pixel", pixel_data, 16'h0AA0);

        // Transparency key on owner 0.
        src_pixels[15:0] = 16'hF81F;
        bg_color = 16'h07E0;
        tick();
        check("transparent_bg", pixel_data, 16'h07E0);
        src_pixels[15:0] = 16'h1234;
        tick();
        check("opaque_pixel", pixel_data, 16'h1234);

        // Mid-frame request drop: grant holds until next frame_begin.
        req = 3'b000;
        repeat (3) tick();
        check("drop_hold_grant", 16'(grant), 16'h0001);
        frame(3'b000, 8'd0);                       // frame 7 -> idle
        tick();
        check("drop_idle_pixel", pixel_data, 16'h07E0);

        // From idle, scan starts after last owner (0): only overlay requests.
        req = 3'b100;
        src_pixels[47:32] = 16'hABCD;
        frame(3'b100, 8'd0);                       // frame 8 (scroll)
        tick();
        check("overlay_pixel", pixel_data, 16'hABCD);
        req = 3'b110;
        frame(3'b100, 8'd1);                       // frame 9: quota not spent
        req = 3'b010;
        repeat (2) tick();
        check("drop2_hold_grant", 16'(grant), 16'h0004);
        frame(3'b010, 8'd0);                       // frame 10 -> next requester

        // Back-to-back frame_begin: two independent arbitrations, two ticks.
        push_frame(3'b010, 8'd1);                  // frame 11
        push_frame(3'b010, 8'd2);                  // frame 12 (scroll)
        @(posedge clk); #1 frame_begin = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 frame_begin = 1'b0;
        tick();
        check("b2b_hold", 16'(hold_count), 16'h0002);
        check("b2b_pixel", pixel_data, 16'hFD20);

        // Asynchronous reset mid-frame: outputs clear without a clock edge.
        #1 reset = 1'b0;
        #2;
        check("async_rst_grant", 16'(grant), 16'h0);
        check("async_rst_pixel", pixel_data, 16'h0000);
        check("async_rst_hold", 16'(hold_count), 16'h0);
        @(posedge clk); #1 reset = 1'b1;
        repeat (4) tick();

        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL scoreboard_drain: got %0d frame results missing, required 0", exp_q.size());
        else
            n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/oled_frame_scheduler.md
# oled_frame_scheduler

Frame-synchronous arbiter that shares the 96x64 OLED pixel stream between three pixel sources: splash, text scroller and status overlay. It sits between the sources and the display driver, runs on the divided OLED clock, and samples the driver's frame_begin strobe. At each frame boundary it grants display ownership to one requester using round-robin with a per-owner frame quota. It then muxes the owner's RGB565 pixel onto the driver's pixel_data input and issues scroll-step and frame ticks to the sources.

## Interface
Parameters:
- MAX_FRAMES, 16, frames an owner may hold while another source is requesting; legal range 1..255
- SCROLL_DIV, 4, frames per scroll_step pulse; legal range 1..255
- TRANSPARENT, 16'hF81F, RGB565 key replaced by bg_color

Ports:
- clk  in  1  OLED clock, the single clock domain
- reset  in  1  asynchronous, active-low; all state clears while low
- frame_begin  in  1  one-cycle strobe from the display driver at frame start
- req  in  3  per-source ownership request, level; bit0 splash, bit1 scroller, bit2 overlay
- src_pixels  in  48  source n pixel on bits [16n+15:16n]
- bg_color  in  16  colour output when idle or transparent
- grant  out  3  one-hot owner, or 3'b000 when idle
- frame_tick  out  1  one-cycle pulse on the cycle after any frame_begin
- scroll_step  out  1  one-cycle pulse, once every SCROLL_DIV frames
- hold_count  out  8  frames the current owner has held; saturates at 255
- pixel_data  out  16  registered pixel to the display driver

## Operation
- Two-state FSM:
  - IDLE: grant is 000.
  - OWNED: grant is one-hot.
- State, grant and hold_count change only in the cycle after a cycle where frame_begin is 1. req is ignored at all other times.
- Arbitration at frame_begin. Let cur be the current owner and last the pointer to the most recent owner.
  - Keep cur if req[cur]=1 AND (hold_count < MAX_FRAMES-1 OR no other req bit is set).
  - Otherwise pick the first set req bit scanning last+1, last+2, last+3 (mod 3). The new owner starts with hold_count=0, and last becomes the new owner.
  - If no req bit is set: go to IDLE with hold_count=0. last is unchanged.
- From IDLE, arbitration uses the same scan from last+1.
- When the owner is kept, hold_count increments and saturates at 255.
- After reset, last=2, so source 0 has the highest priority on the first frame.
- Pixel mux, every clk cycle:
  - pixel_data <= bg_color if in IDLE, or if the owner's pixel equals TRANSPARENT.
  - Otherwise pixel_data <= the owner's src_pixels slice.
- Scroll divider: a frame counter runs 0..SCROLL_DIV-1 and advances on each frame_begin in both states. scroll_step=1 in the frame_tick cycle when the counter wraps from SCROLL_DIV-1 to 0.
- Dropping req mid-frame does not revoke grant. Grant is released only at the next frame_begin.

## Timing
- Reset values:
  - grant=000, frame_tick=0, scroll_step=0, hold_count=0, pixel_data=16'h0000.
  - FSM=IDLE, frame counter=0, last=2.
  - Reset takes effect asynchronously, including mid-frame.
- Grant latency: frame_begin high in cycle T, new grant in T+1, pixel_data from the new owner in T+2.
- pixel_data latency: 1 cycle from src_pixels, bg_color or grant.
- frame_tick and scroll_step are high in cycle T+1 only.
- Back-to-back frame_begin pulses (T and T+1): each is arbitrated independently. frame_tick is high for both T+1 and T+2.
- frame_begin asserted during reset is ignored. The first arbitration is the first frame_begin after release.
- SCROLL_DIV=1: scroll_step equals frame_tick.

## Test plan
- Reset and idle: hold reset low, then release with req=000, bg_color=16'h001F, and pulse frame_begin. Required: grant=000; pixel_data=0 during reset, then 16'h001F from release+1 onward; frame_tick high for 1 cycle.
- Single requester: req=010, src1=16'hFD20, frame_begin at T. Required: grant=010 at T+1; pixel_data=16'hFD20 at T+2; hold_count counts 0,1,2… on later frames.
- Quota rotation: MAX_FRAMES=2, req=011 steady, 6 frames. Required: grant sequence 001,001,010,010,001,001.
- Transparency: owner src0=16'hF81F, bg_color=16'h07E0. Required: pixel_data=16'h07E0. When src0 changes to 16'h1234, pixel_data=16'h1234 one cycle later.
- Scroll divider: SCROLL_DIV=4, 9 frame_begin pulses. Required: scroll_step on frames 4 and 8 only, coincident with frame_tick.
- Mid-frame events: drop req[cur] mid-frame. Required: grant holds until the next frame_begin, then goes to IDLE (or the next requester). Assert reset mid-frame. Required: grant=000 and pixel_data=0 immediately, no clock edge needed.
